vga_trace_draw: RTL and testbench

- Draws the oscilloscope waveform trace into display window 1 (1024x768 @ 60 Hz, 65 MHz pixel clock).
- Sits in the VGA pixel pipeline directly downstream of the timing generator and background stage.
- Fetches one 9-bit sample per window column from the capture sample RAM.
- Joins adjacent samples with a vertical span so the trace has no gaps, and overlays the trace colour on the incoming RGB.
- Signals the capture side once per frame when the buffer has been fully read, so the capture side can swap it.

---
 rtl/vga_trace_draw.sv | 139 +++++++++++++
 tb/tb_vga_trace_draw.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/vga_trace_draw.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
//  Module   : vga_trace_draw
//  Purpose  : Overlays the oscilloscope sample trace on the VGA pixel stream.
//             One 9-bit sample is fetched per window column; adjacent samples
//             are joined by a vertical span. Two-cycle pixel latency.
//  Revision : 1.0 - initial release
// ============================================================================
module vga_trace_draw #(
  parameter int          H_START     = 45,
  parameter int          V_BOTTOM    = 530,
  parameter int          LENGTH      = 768,
  parameter int          HEIGHT      = 512,
  parameter logic [11:0] TRACE_COLOR = 12'hFF0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        trace_en,
  input  logic [10:0] vcount_in,
  input  logic        vsync_in,
  input  logic        vblnk_in,
  input  logic [10:0] hcount_in,
  input  logic        hsync_in,
  input  logic        hblnk_in,
  input  logic [11:0] rgb_in,
  output logic [9:0]  rd_addr,
  input  logic [8:0]  rd_data,
  output logic        frame_done,
  output logic [10:0] vcount_out,
  output logic        vsync_out,
  output logic        vblnk_out,
  output logic [10:0] hcount_out,
  output logic        hsync_out,
  output logic        hblnk_out,
  output logic [11:0] rgb_out
);

  localparam logic [10:0] c_h_first = 11'(H_START);
  localparam logic [10:0] c_h_last  = 11'(H_START + LENGTH - 1);
  localparam logic [10:0] c_v_top   = 11'(V_BOTTOM - HEIGHT + 1);
  localparam logic [10:0] c_v_bot   = 11'(V_BOTTOM);
  localparam logic [9:0]  c_a_last  = 10'(LENGTH - 1);

  logic        w_col_in;
  logic        w_in_win;
  logic [10:0] w_hoff;

  // Stage-1 registers: timing, colour and window flags aligned with rd_data
  logic [10:0] r_vcount_d, r_hcount_d;
  logic        r_vsync_d, r_vblnk_d, r_hsync_d, r_hblnk_d;
  logic [11:0] r_rgb_d;
  logic        r_in_win_d, r_col_in_d, r_col_first_d, r_col_last_d;

  // Sample of the previously drawn column; invalid until the first column after reset
  logic [8:0]  r_prev;
  logic        r_prev_vld;

  logic [10:0] w_y_cur, w_y_prev, w_y_lo, w_y_hi;
  logic        w_draw;

  // Window test and column address from the raw input counters
  always_comb begin
    w_col_in = (hcount_in >= c_h_first) && (hcount_in <= c_h_last);
    w_in_win = w_col_in && (vcount_in >= c_v_top) && (vcount_in <= c_v_bot)
               && !vblnk_in && !hblnk_in;
    w_hoff   = hcount_in - c_h_first;
    rd_addr  = w_col_in ? w_hoff[9:0] : 10'd0;
  end

  // Stage 1: delay timing by one cycle while the sample RAM answers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vcount_d    <= '0;
      r_vsync_d     <= 1'b0;
      r_vblnk_d     <= 1'b0;
      r_hcount_d    <= '0;
      r_hsync_d     <= 1'b0;
      r_hblnk_d     <= 1'b0;
      r_rgb_d       <= '0;
      r_in_win_d    <= 1'b0;
      r_col_in_d    <= 1'b0;
      r_col_first_d <= 1'b0;
      r_col_last_d  <= 1'b0;
    end else begin
      r_vcount_d    <= vcount_in;
      r_vsync_d     <= vsync_in;
      r_vblnk_d     <= vblnk_in;
      r_hcount_d    <= hcount_in;
      r_hsync_d     <= hsync_in;
      r_hblnk_d     <= hblnk_in;
      r_rgb_d       <= rgb_in;
      r_in_win_d    <= w_in_win;
      r_col_in_d    <= w_col_in;
      r_col_first_d <= w_col_in && (rd_addr == 10'd0);
      r_col_last_d  <= w_col_in && (rd_addr == c_a_last);
    end
  end

  // Span between this column's row and the previous column's row
  always_comb begin
    w_y_cur  = c_v_bot - {2'b00, rd_data};
    w_y_prev = (r_col_first_d || !r_prev_vld) ? w_y_cur : (c_v_bot - {2'b00, r_prev});
    w_y_lo   = (w_y_cur < w_y_prev) ? w_y_cur : w_y_prev;
    w_y_hi   = (w_y_cur < w_y_prev) ? w_y_prev : w_y_cur;
    w_draw   = trace_en && r_in_win_d && (r_vcount_d >= w_y_lo) && (r_vcount_d <= w_y_hi);
  end

  // Stage 2: registered outputs, trace overlay and end-of-buffer pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vcount_out <= '0;
      vsync_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      hcount_out <= '0;
      hsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      rgb_out    <= '0;
      frame_done <= 1'b0;
      r_prev     <= '0;
      r_prev_vld <= 1'b0;
    end else begin
      vcount_out <= r_vcount_d;
      vsync_out  <= r_vsync_d;
      vblnk_out  <= r_vblnk_d;
      hcount_out <= r_hcount_d;
      hsync_out  <= r_hsync_d;
      hblnk_out  <= r_hblnk_d;
      rgb_out    <= w_draw ? TRACE_COLOR : r_rgb_d;
      frame_done <= r_col_last_d && (r_vcount_d == c_v_bot);
      if (r_col_in_d) begin
        r_prev     <= rd_data;
        r_prev_vld <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vga_trace_draw.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
//  Module   : tb_vga_trace_draw
//  Purpose  : Self-checking bench for vga_trace_draw with a pixel-level
//             reference model and a synchronous sample RAM model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vga_trace_draw;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        trace_en = 1'b0;
  logic [10:0] vcount_in = '0, hcount_in = '0;
  logic        vsync_in = 1'b0, vblnk_in = 1'b0, hsync_in = 1'b0, hblnk_in = 1'b0;
  logic [11:0] rgb_in = '0;
  logic [9:0]  rd_addr;
  logic [8:0]  rd_data = '0;
  logic        frame_done;
  logic [10:0] vcount_out, hcount_out;
  logic        vsync_out, vblnk_out, hsync_out, hblnk_out;
  logic [11:0] rgb_out;

  vga_trace_draw dut (
    .clk(clk), .rst_n(rst_n), .trace_en(trace_en),
    .vcount_in(vcount_in), .vsync_in(vsync_in), .vblnk_in(vblnk_in),
    .hcount_in(hcount_in), .hsync_in(hsync_in), .hblnk_in(hblnk_in),
    .rgb_in(rgb_in), .rd_addr(rd_addr), .rd_data(rd_data),
    .frame_done(frame_done),
    .vcount_out(vcount_out), .vsync_out(vsync_out), .vblnk_out(vblnk_out),
    .hcount_out(hcount_out), .hsync_out(hsync_out), .hblnk_out(hblnk_out),
    .rgb_out(rgb_out)
  );

  always #5 clk = ~clk;

  // Sample buffer contents and a one-cycle read latency RAM serving the DUT
  int smp [768];
  always @(posedge clk) rd_data <= 9'(smp[rd_addr]);

  logic [38:0] out_bus;
  assign out_bus = {vcount_out, vsync_out, vblnk_out, hcount_out, hsync_out,
                    hblnk_out, rgb_out, frame_done};

  int n_checks = 0;
  int n_errors = 0;
  int fd_cnt   = 0;

  always @(negedge clk) if (rst_n && frame_done) fd_cnt++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: a pixel is trace-coloured when its row lies between the
  // screen rows of this column's sample and of the column drawn before it.
  int last_smp;
  bit last_vld;
  logic [38:0] exp_q[$];

  task automatic model(input int h, input int v, output logic [38:0] e);
    bit   col_in, win, draw, fd;
    int   c, a, b, top, bot;
    logic [11:0] col;
    col_in = (h >= 45) && (h <= 812);
    win    = col_in && (v >= 19) && (v <= 530) && !hblnk_in && !vblnk_in;
    draw   = 1'b0;
    fd     = 1'b0;
    if (col_in) begin
      c = h - 45;
      a = smp[c];
      b = (c == 0 || !last_vld) ? a : last_smp;
      last_smp = a;
      last_vld = 1'b1;
      top  = 530 - ((a > b) ? a : b);
      bot  = 530 - ((a < b) ? a : b);
      draw = trace_en && win && (v >= top) && (v <= bot);
      fd   = (c == 767) && (v == 530);
    end
    col = draw ? 12'hFF0 : rgb_in;
    e = {11'(v), vsync_in, vblnk_in, 11'(h), hsync_in, hblnk_in, col, fd};
  endtask

  // One pixel: check the output due two cycles after its input, then drive the next input
  task automatic pix(input int h, input int v);
    logic [38:0] e;
    @(posedge clk);
    #1;
    if (exp_q.size() == 2) check("pix", out_bus, exp_q.pop_front());
    hcount_in = 11'(h);
    vcount_in = 11'(v);
    hblnk_in  = (h >= 1024);
    hsync_in  = (h >= 1048) && (h <= 1183);
    vblnk_in  = (v >= 768);
    vsync_in  = (v >= 771) && (v <= 776);
    rgb_in    = 12'($urandom);
    model(h, v, e);
    exp_q.push_back(e);
    #1;
    check("rd_addr", rd_addr, (h >= 45 && h <= 812) ? 10'(h - 45) : 10'd0);
  endtask

  task automatic mid_reset();
    logic [38:0] e;
    #2 rst_n = 1'b0;
    #1 check("async_reset", out_bus, 39'd0);
    @(negedge clk);
    check("reset_hold", out_bus, 39'd0);
    rst_n = 1'b1;
    exp_q.delete();
    last_vld = 1'b0;
    model(int'(hcount_in), int'(vcount_in), e);
    exp_q.push_back(e);
  endtask

  int rows[12] = '{18, 19, 20, 300, 429, 430, 431, 529, 530, 531, 600, 772};

  task automatic frame(input bit en, input bit do_rst);
    trace_en = en;
    foreach (rows[r]) begin
      for (int h = 40; h <= 830; h++) begin
        pix(h, rows[r]);
        if (do_rst && rows[r] == 300 && h == 400) mid_reset();
      end
      for (int h = 1030; h <= 1050; h++) pix(h, rows[r]);
    end
    for (int k = 0; k < 3; k++) pix(1100, 800);
    check("frame_done_cnt", fd_cnt, 1);
    fd_cnt = 0;
  endtask

  initial begin
    last_vld = 1'b0;
    last_smp = 0;
    foreach (smp[i]) smp[i] = 0;
    repeat (3) @(posedge clk);
    #1 check("reset_state", out_bus, 39'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (smp[i]) smp[i] = 100;
    frame(1'b1, 1'b0);

    foreach (smp[i]) smp[i] = (i % 2 == 0) ? 0 : 511;
    frame(1'b1, 1'b0);

    foreach (smp[i]) smp[i] = (i < 10) ? 200 : 300;
    frame(1'b1, 1'b0);

    foreach (smp[i]) smp[i] = int'($urandom_range(511, 0));
    frame(1'b0, 1'b0);

    foreach (smp[i]) smp[i] = int'($urandom_range(511, 0));
    frame(1'b1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
